// File: rtl/counter_sequencer.sv
// Command-driven 8-bit counter sequencer: loads a start value, counts toward a
// limit, and reloads for a programmed number of passes before pulsing done.
module counter_sequencer #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic             cmd_dir,
  input  logic [REP_W-1:0] cmd_repeat,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic [REP_W-1:0] pass_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q, start_q, limit_q;
  logic [REP_W-1:0] pass_q, rep_q;
  logic             dir_q, done_q;
  logic [WIDTH-1:0] step_d;

  // Natural modulo-2^WIDTH arithmetic gives the legal wrap-around for free.
  assign step_d    = dir_q ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
  assign tc        = (state_q == S_RUN) && (count_q == limit_q) && !pause;
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign count     = count_q;
  assign pass_idx  = pass_q;
  assign done      = done_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      count_q <= '0;
      start_q <= '0;
      limit_q <= '0;
      dir_q   <= 1'b0;
      rep_q   <= '0;
      pass_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            start_q <= cmd_start;
            limit_q <= cmd_limit;
            dir_q   <= cmd_dir;
            rep_q   <= cmd_repeat;
            count_q <= cmd_start;
            pass_q  <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          // abort > pause > tc > step; pause already masks tc.
          if (abort) begin
            state_q <= S_IDLE;
          end else if (pause) begin
            count_q <= count_q;
          end else if (tc) begin
            if (pass_q == rep_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              count_q <= start_q;
              pass_q  <= pass_q + REP_W'(1);
            end
          end else begin
            count_q <= step_d;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
